// File: rtl/lsu_v1.sv
// lsu_v1: RV32 load/store unit that turns byte-addressed B/H/W accesses into word-wide memory
// transactions, using read-modify-write for sub-word stores. Optional macro: LSU_MISALIGN_ERR_EN.
module lsu_v1 #(
    parameter int unsigned addr_width = 10,
    parameter int unsigned data_width = 32,
    parameter int unsigned MEM_RD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic [addr_width-1:0] mem_addr,
    output logic [data_width-1:0] mem_wdata,
    input  logic [data_width-1:0] mem_rdata,
    output logic                  mem_we
);

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

    localparam logic [2:0] F3B  = 3'b000;
    localparam logic [2:0] F3H  = 3'b001;
    localparam logic [2:0] F3W  = 3'b010;
    localparam logic [2:0] F3Bu = 3'b100;
    localparam logic [2:0] F3Hu = 3'b101;

    state_e                state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [1:0]            lane_q, lane_d;
    logic [addr_width-1:0] mem_addr_q, mem_addr_d;
    logic [data_width-1:0] mem_wdata_q, mem_wdata_d;
    logic [31:0]           rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;

    logic        funct3_ok;
    logic        range_err;
    logic        misalign;
    logic        req_err;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_data;
    logic [31:0] store_word;

    always_comb begin
        funct3_ok = 1'b0;
        case (req_funct3)
            F3B, F3H, F3W: funct3_ok = 1'b1;
            F3Bu, F3Hu:    funct3_ok = !req_we;
            default:       funct3_ok = 1'b0;
        endcase
    end

    assign range_err = (req_addr >> (addr_width + 2)) != 32'd0;

`ifdef LSU_MISALIGN_ERR_EN
    assign misalign = ((req_funct3 == F3H || req_funct3 == F3Hu) && req_addr[0])
                    || (req_funct3 == F3W && req_addr[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    assign req_err = !funct3_ok || range_err || misalign;

    // Lane extraction from the word currently on the memory read port.
    always_comb begin
        rd_byte = mem_rdata[{lane_q, 3'b000} +: 8];
        rd_half = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q)
            F3B:     load_data = {{24{rd_byte[7]}}, rd_byte};
            F3H:     load_data = {{16{rd_half[15]}}, rd_half};
            F3Bu:    load_data = {24'b0, rd_byte};
            F3Hu:    load_data = {16'b0, rd_half};
            default: load_data = mem_rdata;
        endcase
    end

    // Store data is parked in mem_wdata_q until the read word arrives for the merge.
    always_comb begin
        store_word = mem_rdata;
        if (funct3_q == F3B) begin
            store_word[{lane_q, 3'b000} +: 8] = mem_wdata_q[7:0];
        end else begin
            store_word[{lane_q[1], 4'b0000} +: 16] = mem_wdata_q[15:0];
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        funct3_d    = funct3_q;
        lane_d      = lane_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    we_d        = req_we;
                    funct3_d    = req_funct3;
                    lane_d      = req_addr[1:0];
                    mem_addr_d  = req_addr[addr_width+1:2];
                    mem_wdata_d = req_wdata;
                    cnt_d       = 3'(MEM_RD_LAT);
                    if (req_err) begin
                        state_d     = StDone;
                        rsp_rdata_d = 32'd0;
                        rsp_err_d   = 1'b1;
                    end else if (req_we && req_funct3 == F3W) begin
                        state_d = StWrite;
                    end else begin
                        state_d = StRead;
                    end
                end
            end
            StRead: begin
                if (cnt_q == 3'd0) begin
                    if (we_q) begin
                        mem_wdata_d = store_word;
                        state_d     = StWrite;
                    end else begin
                        rsp_rdata_d = load_data;
                        rsp_err_d   = 1'b0;
                        state_d     = StDone;
                    end
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            StWrite: begin
                rsp_rdata_d = 32'd0;
                rsp_err_d   = 1'b0;
                state_d     = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= 3'd0;
            we_q        <= 1'b0;
            funct3_q    <= 3'd0;
            lane_q      <= 2'd0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            funct3_q    <= funct3_d;
            lane_q      <= lane_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = state_q == StIdle;
    assign rsp_valid = state_q == StDone;
    assign mem_we    = state_q == StWrite;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_lsu_v1.sv
// tb_lsu_v1: directed table, hand-written corner sequences and random traffic for lsu_v1,
// checked against a byte-level reference model and a word memory with MEM_RD_LAT read latency.
`timescale 1ns/1ps
module tb_lsu_v1;

    localparam int unsigned AW  = 10;
    localparam int unsigned LAT = 1;
    localparam int LD_LAT = int'(LAT) + 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [2:0]    req_funct3;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic          mem_we;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lsu_v1 #(
        .addr_width(AW),
        .data_width(32),
        .MEM_RD_LAT(LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_funct3(req_funct3),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_we    (mem_we)
    );

    // Word memory with a LAT-deep read pipeline and a backdoor write port for preloading.
    logic [31:0]   mem     [0:1023];
    logic [31:0]   rd_pipe [0:LAT-1];
    logic          bd_we;
    logic [AW-1:0] bd_addr;
    logic [31:0]   bd_data;

    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        else if (mem_we) mem[mem_addr] <= mem_wdata;
        rd_pipe[0] <= mem[mem_addr];
        for (int i = 1; i < int'(LAT); i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[LAT-1];

    logic [31:0] ref_mem [0:1023];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic bd_write(input int idx, input logic [31:0] data);
        @(negedge clk);
        bd_we   = 1'b1;
        bd_addr = AW'(idx);
        bd_data = data;
        @(negedge clk);
        bd_we = 1'b0;
        ref_mem[idx] = data;
    endtask

    // Reference: expected error, load data, response latency and write count for one request.
    function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                  input logic [31:0] wdata, output logic err,
                                  output logic [31:0] rdata, output int lat, output int nw);
        int size;
        int sh;
        int idx;
        logic [31:0] word;
        logic [31:0] mask;
        logic [31:0] v;
        err = (addr >= 32'h1000) || f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7 || (we && f3[2]);
`ifdef LSU_MISALIGN_ERR_EN
        if (f3[1:0] == 2'b01 && addr[0]) err = 1'b1;
        if (f3 == 3'b010 && addr[1:0] != 2'b00) err = 1'b1;
`endif
        rdata = 32'd0;
        nw    = 0;
        lat   = 1;
        if (err) return;
        idx  = int'(addr[11:2]);
        size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        sh   = 8 * (int'(addr[1:0]) & ~(size - 1) & 3);
        word = ref_mem[idx];
        mask = (size == 1) ? 32'hFF : (size == 2) ? 32'hFFFF : 32'hFFFF_FFFF;
        if (!we) begin
            v = (word >> sh) & mask;
            if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~mask;
            rdata = v;
            lat   = LD_LAT;
        end else begin
            ref_mem[idx] = (word & ~(mask << sh)) | ((wdata & mask) << sh);
            nw  = 1;
            lat = (size == 4) ? 2 : LD_LAT + 1;
        end
    endfunction

    // Issue one request and watch up to 20 cycles for mem_we and the response pulse.
    task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, output int rsp_cyc,
                           output logic [31:0] rdata, output logic err, output int we_cyc,
                           output int we_cnt, output logic [31:0] we_data,
                           output logic [AW-1:0] we_addr);
        rsp_cyc = 0;
        rdata   = 32'd0;
        err     = 1'b0;
        we_cyc  = 0;
        we_cnt  = 0;
        we_data = 32'd0;
        we_addr = '0;
        @(negedge clk);
        check("req_ready before request", {31'b0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (mem_we) begin
                we_cnt++;
                we_cyc  = k;
                we_data = mem_wdata;
                we_addr = mem_addr;
            end
            if (rsp_valid) begin
                rsp_cyc = k;
                rdata   = rsp_rdata;
                err     = rsp_err;
                break;
            end
        end
        @(negedge clk);
        check("rsp_valid single pulse", {31'b0, rsp_valid}, 32'd0);
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;
        string       name;
    } vec_t;

    vec_t vecs [0:7];

    int            r_cyc, r_wcyc, r_wcnt, e_lat, e_nw, seen;
    logic [31:0]   r_rdata, r_wdata, e_rdata, t_addr, t_wdata;
    logic          r_err, e_err, t_we;
    logic [2:0]    t_f3;
    logic [AW-1:0] r_waddr;

    initial begin
        vecs[0] = '{1'b0, 3'b000, 32'h13, 1'b0, 32'hFFFF_FF80, LD_LAT, "lb 0x13"};
        vecs[1] = '{1'b0, 3'b100, 32'h13, 1'b0, 32'h0000_0080, LD_LAT, "lbu 0x13"};
        vecs[2] = '{1'b0, 3'b001, 32'h10, 1'b0, 32'h0000_7F01, LD_LAT, "lh 0x10"};
        vecs[3] = '{1'b0, 3'b101, 32'h12, 1'b0, 32'h0000_80FF, LD_LAT, "lhu 0x12"};
        vecs[4] = '{1'b0, 3'b010, 32'h1000, 1'b1, 32'h0, 1, "lw out of range"};
        vecs[5] = '{1'b0, 3'b011, 32'h10, 1'b1, 32'h0, 1, "funct3 011"};
        vecs[6] = '{1'b1, 3'b101, 32'h10, 1'b1, 32'h0, 1, "store with hu"};
`ifdef LSU_MISALIGN_ERR_EN
        vecs[7] = '{1'b0, 3'b010, 32'h12, 1'b1, 32'h0, 1, "lw misaligned"};
`else
        vecs[7] = '{1'b0, 3'b010, 32'h12, 1'b0, 32'h80FF_7F01, LD_LAT, "lw misaligned"};
`endif

        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
        bd_we = 1'b0; bd_addr = '0; bd_data = 32'd0;
        repeat (3) @(negedge clk);
        check("reset req_ready", {31'b0, req_ready}, 32'd1);
        check("reset rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("reset rsp_rdata", rsp_rdata, 32'd0);
        check("reset rsp_err", {31'b0, rsp_err}, 32'd0);
        check("reset mem_we", {31'b0, mem_we}, 32'd0);
        check("reset mem_addr", 32'(mem_addr), 32'd0);
        check("reset mem_wdata", mem_wdata, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) bd_write(i, $urandom);

        // Word store: one write at T+1, response at T+2.
        run_req(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, r_cyc, r_rdata, r_err, r_wcyc, r_wcnt,
                r_wdata, r_waddr);
        check("sw write count", 32'(r_wcnt), 32'd1);
        check("sw write cycle", 32'(r_wcyc), 32'd1);
        check("sw mem_addr", 32'(r_waddr), 32'd4);
        check("sw mem_wdata", r_wdata, 32'hDEAD_BEEF);
        check("sw rsp cycle", 32'(r_cyc), 32'd2);
        check("sw rsp_err", {31'b0, r_err}, 32'd0);
        check("sw memory word", mem[4], 32'hDEAD_BEEF);

        bd_write(4, 32'h80FF_7F01);
        for (int v = 0; v < 8; v++) begin
            run_req(vecs[v].we, vecs[v].f3, vecs[v].addr, 32'h5555_AAAA, r_cyc, r_rdata, r_err,
                    r_wcyc, r_wcnt, r_wdata, r_waddr);
            check({vecs[v].name, " rsp cycle"}, 32'(r_cyc), 32'(vecs[v].exp_lat));
            check({vecs[v].name, " rsp_err"}, {31'b0, r_err}, {31'b0, vecs[v].exp_err});
            check({vecs[v].name, " rsp_rdata"}, r_rdata, vecs[v].exp_rdata);
            check({vecs[v].name, " no write"}, 32'(r_wcnt), 32'd0);
        end

        // Byte store read-modify-write, then read back the merged word.
        bd_write(4, 32'h1122_3344);
        run_req(1'b1, 3'b000, 32'h11, 32'h0000_00AB, r_cyc, r_rdata, r_err, r_wcyc, r_wcnt,
                r_wdata, r_waddr);
        check("sb write cycle", 32'(r_wcyc), 32'(LD_LAT));
        check("sb mem_wdata", r_wdata, 32'h1122_AB44);
        check("sb rsp cycle", 32'(r_cyc), 32'(LD_LAT + 1));
        check("sb rsp_rdata", r_rdata, 32'd0);
        run_req(1'b0, 3'b010, 32'h10, 32'd0, r_cyc, r_rdata, r_err, r_wcyc, r_wcnt,
                r_wdata, r_waddr);
        check("lw after sb", r_rdata, 32'h1122_AB44);

        // Reset during the READ phase of a halfword store abandons it.
        bd_write(5, 32'hCAFE_F00D);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001;
        req_addr = 32'h16; req_wdata = 32'h0000_1234;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("sh busy in read", {31'b0, req_ready}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("reset mid-op req_ready", {31'b0, req_ready}, 32'd1);
        check("reset mid-op mem_we", {31'b0, mem_we}, 32'd0);
        check("reset mid-op rsp_valid", {31'b0, rsp_valid}, 32'd0);
        rst = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid || mem_we) seen++;
        end
        check("abandoned sh quiet", 32'(seen), 32'd0);
        check("abandoned sh memory", mem[5], 32'hCAFE_F00D);

        // Random traffic against the reference model.
        for (int i = 0; i < 16; i++) bd_write(i, $urandom);
        for (int n = 0; n < 300; n++) begin
            t_we = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 10))
                0, 1:    t_f3 = 3'b000;
                2, 3:    t_f3 = 3'b001;
                4, 5:    t_f3 = 3'b010;
                6, 7:    t_f3 = 3'b100;
                8, 9:    t_f3 = 3'b101;
                default: t_f3 = 3'($urandom_range(0, 7));
            endcase
            t_addr = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) t_addr = t_addr | (32'd1 << $urandom_range(12, 31));
            t_wdata = $urandom;
            model(t_we, t_f3, t_addr, t_wdata, e_err, e_rdata, e_lat, e_nw);
            run_req(t_we, t_f3, t_addr, t_wdata, r_cyc, r_rdata, r_err, r_wcyc, r_wcnt,
                    r_wdata, r_waddr);
            check("rand rsp cycle", 32'(r_cyc), 32'(e_lat));
            check("rand rsp_err", {31'b0, r_err}, {31'b0, e_err});
            check("rand rsp_rdata", r_rdata, e_rdata);
            check("rand write count", 32'(r_wcnt), 32'(e_nw));
            if (e_nw != 0) check("rand memory word", mem[t_addr[11:2]], ref_mem[t_addr[11:2]]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
